data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
Responder (slave) end of the MEM-stage data-memory interface driven by the pipeline controller's mem_ren/mem_wen decode.
- Accepts one word read or write per request and completes it after a fixed LATENCY.
- Holds mem_stall high so the pipeline freezes until the access completes.
- Sits between the MEM stage and the data RAM; replaces the ideal single-cycle memory model.

Parameters:
LATENCY, 2, cycles from acceptance to completion; legal range 1..15.
DEPTH_WORDS, 1024, number of 32-bit words; power of two.
ADDR_W, log2(DEPTH_WORDS), word-index width; derived, not overridable.

Ports:
clk  input  1  clock; all state changes on posedge.
rst  input  1  reset, synchronous, active-high.
mem_ren  input  1  read request from MEM stage; held stable while mem_stall=1.
mem_wen  input  1  write request from MEM stage; held stable while mem_stall=1.
mem_addr  input  32  byte address.
mem_din  input  32  write data.
mem_dout  output  32  read data; valid only while resp_valid=1.
resp_valid  output  1  one-cycle completion pulse for reads and writes.
mem_stall  output  1  stall request to the pipeline controller.
mem_err  output  1  alignment error flag; accompanies resp_valid.

Behaviour:
- FSM states: IDLE, BUSY, DONE. 4-bit down-counter cnt.
- Reset (rst=1 at posedge):
  - state=IDLE, cnt=0, mem_dout=0, resp_valid=0, mem_err=0.
  - Latched request is discarded; no RAM write occurs.
  - RAM contents are not cleared.
  - Reset mid-BUSY aborts the access; mem_stall is low the cycle after.
- IDLE, cycle T, (mem_ren|mem_wen)=1:
  - Latch op, word index mem_addr[ADDR_W+1:2], and mem_din.
  - cnt <= LATENCY-1.
  - Next state: BUSY if LATENCY>1, else DONE.
- BUSY: cnt decrements each cycle; when cnt==1 the next state is DONE.
- DONE, cycle T+LATENCY:
  - resp_valid=1.
  - Read: mem_dout = RAM[index].
  - Write: RAM[index] <= data at the end of this cycle.
  - Next state: IDLE unconditionally. Inputs are ignored in DONE, because the same request is still presented.
- mem_stall (combinational):
  - 1 in IDLE when (mem_ren|mem_wen)=1.
  - 1 throughout BUSY.
  - 0 in DONE and in IDLE with no request.
  - Net effect: high for exactly cycles T..T+LATENCY-1.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE. Throughput is 1 access per LATENCY+1 cycles.
- mem_ren and mem_wen both high: treated as a write; the read is dropped.
- Address upper bits above ADDR_W+1 are ignored, so the address wraps modulo DEPTH_WORDS*4.
- Changes on mem_addr/mem_din while stalled are ignored; the latched copy is used.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined: mem_addr[1:0]!=0 at acceptance sets an err flag.
  - In DONE: mem_err=1 with resp_valid, no RAM write, mem_dout=0.
  - Timing and stall are unchanged.
- Undefined: mem_addr[1:0] is ignored and mem_err is tied to 0.

Decomposition:
- Shared package/header holds:
  - state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - LATENCY_MAX=15;
  - the counter width constant (4).
- One sub-module, data_mem_array:
  - single-port synchronous RAM, DEPTH_WORDS x 32;
  - ports: clk, we, addr[ADDR_W-1:0], din, dout;
  - read-during-write returns old data.

Test Plan:
1. Write then read, LATENCY=2:
   - wen, addr=0x10, din=0xDEADBEEF → mem_stall high 2 cycles, resp_valid on 3rd cycle.
   - Then ren, addr=0x10 → mem_dout=0xDEADBEEF with resp_valid.
2. LATENCY=1:
   - ren at cycle T → mem_stall high only at T, resp_valid at T+1, IDLE at T+2.
3. Reset mid-access:
   - wen, addr=0x20, din=0x12345678; rst at T+1 → mem_stall=0 at T+2.
   - Subsequent read of 0x20 → previous value (0 after power-up init), not 0x12345678.
4. Wrap and priority:
   - wen, addr=0x1000+0x4 (DEPTH_WORDS=1024), din=0xA5A5A5A5; then read 0x4 → 0xA5A5A5A5.
   - ren=wen=1, addr=0x8, din=0x1 → write performed; read of 0x8 returns 0x1.
5. Back-to-back reads, LATENCY=3:
   - ren held for two requests → resp_valid pulses 4 cycles apart.
   - mem_stall=0 in each DONE cycle and high 3 cycles per request.
6. MEM_ALIGN_CHECK_EN defined:
   - wen, addr=0x12, din=0xFFFFFFFF → mem_err=1 with resp_valid; read of 0x10 is unchanged.
   - Undefined: same stimulus writes word 0x10 and mem_err=0.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder and its RAM.
// Holds the FSM state encoding, the latency ceiling and the countdown width.
package data_mem_responder_pkg;

    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_responder_array.sv
// Single-port synchronous word RAM (DEPTH_WORDS x 32) with a registered read port.
// A read of the word being written returns the old contents.
module data_mem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    output logic [31:0]       dout
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= din;
        end
        dout <= mem_q[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the MEM-stage data-memory interface: fixed-latency word access with stall.
// Optional build macro MEM_ALIGN_CHECK_EN flags misaligned byte addresses via mem_err.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_din,
    output logic [31:0] mem_dout,
    output logic        resp_valid,
    output logic        mem_stall,
    output logic        mem_err
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       din_q, din_d;

    logic              req;
    logic              req_err;
    logic [ADDR_W-1:0] req_idx;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_dout;
    logic              unused_addr_bits;

    assign req     = mem_ren | mem_wen;
    assign req_idx = mem_addr[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    assign req_err = (mem_addr[1:0] != 2'b00);
`else
    assign req_err = 1'b0;
`endif

    // Upper address bits wrap away; the byte-offset bits only matter to the alignment check.
    assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        err_d   = err_q;
        idx_d   = idx_q;
        din_d   = din_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    // A simultaneous read+write is a write; the read is dropped.
                    wr_d    = mem_wen;
                    err_d   = req_err;
                    idx_d   = req_idx;
                    din_d   = mem_din;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY > 1) ? BUSY : DONE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The same request is still presented here, so inputs are ignored.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // In IDLE the RAM reads the live index so a LATENCY=1 read has data by DONE.
    assign ram_addr   = (state_q == IDLE) ? req_idx : idx_q;
    assign ram_we     = (state_q == DONE) && wr_q && !err_q && !rst;

    assign mem_stall  = ((state_q == IDLE) && req) || (state_q == BUSY);
    assign resp_valid = (state_q == DONE);
    assign mem_err    = (state_q == DONE) && err_q;
    assign mem_dout   = ((state_q == DONE) && !wr_q && !err_q) ? ram_dout : 32'h0;

    data_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_array (
        .clk (clk),
        .we  (ram_we),
        .addr(ram_addr),
        .din (din_q),
        .dout(ram_dout)
    );

endmodule
